ball_keygen: RTL and testbench

BALL_KEYGEN -- requirements
Module: ball_keygen

---
 rtl/ball_keygen.sv | 151 +++++++++++++++
 tb/tb_ball_keygen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ball_keygen.sv
// Keyboard report -> per-ball steering codes; optional stale timeout via BALL_KEYGEN_STALE_TIMEOUT_EN.
// Latency: report captured at edge N, keycodes/press pulses update at edge N+5.
// Backpressure: report_ready high only in IDLE; reports offered while busy are dropped, not queued.
module ball_keygen #(
    parameter logic [7:0] RED_CW       = 8'h07,
    parameter logic [7:0] RED_CCW      = 8'h04,
    parameter logic [7:0] BLUE_CW      = 8'h4F,
    parameter logic [7:0] BLUE_CCW     = 8'h50,
    parameter logic [7:0] STALE_FRAMES = 8'd60
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        report_valid,
    input  logic [31:0] report_keys,
    output logic        report_ready,
    output logic [7:0]  keycode_red,
    output logic [7:0]  keycode_blue,
    output logic        press_red,
    output logic        press_blue,
    output logic        stale
);

    localparam logic [7:0] CODE_CW   = 8'd7;
    localparam logic [7:0] CODE_CCW  = 8'd4;
    localparam logic [7:0] CODE_NONE = 8'd0;

    typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_keys;
    logic        r_red_cw, r_red_ccw, r_blue_cw, r_blue_ccw;
    logic [7:0]  r_key_red, r_key_blue;
    logic        r_press_red, r_press_blue;

    logic        w_capture;
    logic [7:0]  w_byte;
    logic [7:0]  w_red_next, w_blue_next;

    assign w_capture = (r_state == IDLE) && report_valid;

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            2'd0: w_byte = r_keys[7:0];
            2'd1: w_byte = r_keys[15:8];
            2'd2: w_byte = r_keys[23:16];
            2'd3: w_byte = r_keys[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    // Opposing directions on the same ball cancel to no steering.
    always_comb begin
        w_red_next = CODE_NONE;
        if (r_red_cw && !r_red_ccw)
            w_red_next = CODE_CW;
        else if (r_red_ccw && !r_red_cw)
            w_red_next = CODE_CCW;
        w_blue_next = CODE_NONE;
        if (r_blue_cw && !r_blue_ccw)
            w_blue_next = CODE_CW;
        else if (r_blue_ccw && !r_blue_cw)
            w_blue_next = CODE_CCW;
    end

`ifdef BALL_KEYGEN_STALE_TIMEOUT_EN
    logic [7:0] r_stale_cnt;
    logic       r_stale;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_keys       <= 32'h0;
            r_red_cw     <= 1'b0;
            r_red_ccw    <= 1'b0;
            r_blue_cw    <= 1'b0;
            r_blue_ccw   <= 1'b0;
            r_key_red    <= CODE_NONE;
            r_key_blue   <= CODE_NONE;
            r_press_red  <= 1'b0;
            r_press_blue <= 1'b0;
`ifdef BALL_KEYGEN_STALE_TIMEOUT_EN
            r_stale_cnt  <= 8'd0;
            r_stale      <= 1'b0;
`endif
        end else begin
            r_press_red  <= 1'b0;
            r_press_blue <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_keys     <= report_keys;
                        r_red_cw   <= 1'b0;
                        r_red_ccw  <= 1'b0;
                        r_blue_cw  <= 1'b0;
                        r_blue_ccw <= 1'b0;
                        r_idx      <= 2'd0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_byte == RED_CW)   r_red_cw   <= 1'b1;
                    if (w_byte == RED_CCW)  r_red_ccw  <= 1'b1;
                    if (w_byte == BLUE_CW)  r_blue_cw  <= 1'b1;
                    if (w_byte == BLUE_CCW) r_blue_ccw <= 1'b1;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3)
                        r_state <= PUBLISH;
                end
                PUBLISH: begin
                    r_key_red    <= w_red_next;
                    r_key_blue   <= w_blue_next;
                    r_press_red  <= (r_key_red == CODE_NONE) && (w_red_next != CODE_NONE);
                    r_press_blue <= (r_key_blue == CODE_NONE) && (w_blue_next != CODE_NONE);
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
`ifdef BALL_KEYGEN_STALE_TIMEOUT_EN
            if (w_capture)
                r_stale_cnt <= 8'd0;
            else if (r_stale_cnt != 8'hFF)
                r_stale_cnt <= r_stale_cnt + 8'd1;

            // A capture on the same edge suppresses the timeout.
            if (r_state == PUBLISH)
                r_stale <= 1'b0;
            else if ((r_state == IDLE) && !w_capture && (r_stale_cnt >= STALE_FRAMES)) begin
                r_key_red  <= CODE_NONE;
                r_key_blue <= CODE_NONE;
                r_stale    <= 1'b1;
            end
`endif
        end
    end

    assign report_ready = (r_state == IDLE);
    assign keycode_red  = r_key_red;
    assign keycode_blue = r_key_blue;
    assign press_red    = r_press_red;
    assign press_blue   = r_press_blue;
`ifdef BALL_KEYGEN_STALE_TIMEOUT_EN
    assign stale = r_stale;
`else
    assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_ball_keygen.sv
// Directed bench for ball_keygen: expected publishes go into a queue, a negedge monitor checks them.
module tb_ball_keygen;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        report_valid = 1'b0;
    logic [31:0] report_keys = 32'h0;
    logic        report_ready;
    logic [7:0]  keycode_red, keycode_blue;
    logic        press_red, press_blue, stale;

    ball_keygen dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .report_valid (report_valid),
        .report_keys  (report_keys),
        .report_ready (report_ready),
        .keycode_red  (keycode_red),
        .keycode_blue (keycode_blue),
        .press_red    (press_red),
        .press_blue   (press_blue),
        .stale        (stale)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  b;
        logic        pr;
        logic        pb;
        logic [31:0] cap;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    logic prev_rdy = 1'b1;
    logic post_chk = 1'b0;

    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    endtask

    // Monitor: a rising report_ready marks a publish edge.
    always @(negedge frame_clk) begin
        exp_t e;
        if (Reset) begin
            prev_rdy = 1'b1;
            post_chk = 1'b0;
        end else begin
            if (post_chk) begin
                chk("press_red_width", {31'd0, press_red}, 32'd0);
                chk("press_blue_width", {31'd0, press_blue}, 32'd0);
                post_chk = 1'b0;
            end
            if (report_ready && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_publish: red %0h blue %0h with no report pending", keycode_red, keycode_blue);
                end else begin
                    e = exp_q.pop_front();
                    chk("keycode_red", {24'd0, keycode_red}, {24'd0, e.r});
                    chk("keycode_blue", {24'd0, keycode_blue}, {24'd0, e.b});
                    chk("press_red", {31'd0, press_red}, {31'd0, e.pr});
                    chk("press_blue", {31'd0, press_blue}, {31'd0, e.pb});
                    chk("stale_at_publish", {31'd0, stale}, 32'd0);
                    chk("latency", cyc - e.cap, 32'd5);
                    post_chk = 1'b1;
                end
            end
            prev_rdy = report_ready;
        end
    end

    task automatic send(input logic [31:0] keys, input int hold, input logic push,
                        input logic [7:0] er, input logic [7:0] eb, input logic epr, input logic epb);
        int t = 0;
        exp_t e;
        @(negedge frame_clk);
        while (!report_ready && t < 100) begin
            @(negedge frame_clk);
            t++;
        end
        if (t >= 100) begin
            n_total++;
            $display("FAIL ready_timeout: report_ready stayed %0b for %0d cycles", report_ready, t);
        end
        report_keys  = keys;
        report_valid = 1'b1;
        @(posedge frame_clk);
        #1;
        // Scrambled keys after capture must not leak into the scan.
        report_keys = 32'h4F50_0704;
        if (push) begin
            e.r = er; e.b = eb; e.pr = epr; e.pb = epb; e.cap = cyc;
            exp_q.push_back(e);
        end
        repeat (hold) @(posedge frame_clk);
        #1;
        report_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge frame_clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d publishes still pending", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge frame_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge frame_clk);
        @(negedge frame_clk);
        chk("rst_red", {24'd0, keycode_red}, 32'd0);
        chk("rst_blue", {24'd0, keycode_blue}, 32'd0);
        chk("rst_press", {30'd0, press_red, press_blue}, 32'd0);
        chk("rst_stale", {31'd0, stale}, 32'd0);
        @(posedge frame_clk);
        #1 Reset = 1'b0;
        @(negedge frame_clk);
        chk("ready_after_reset", {31'd0, report_ready}, 32'd1);

        send(32'h0000_0007, 0, 1'b1, 8'd7, 8'd0, 1'b1, 1'b0);
        send(32'h0704_4F00, 0, 1'b1, 8'd0, 8'd7, 1'b0, 1'b1);
        send(32'h0000_0004, 0, 1'b1, 8'd4, 8'd0, 1'b1, 1'b0);
        send(32'h0000_0007, 3, 1'b1, 8'd7, 8'd0, 1'b0, 1'b0);
        send(32'h0707_1150, 0, 1'b1, 8'd7, 8'd4, 1'b0, 1'b1);
        drain();

        // Abort a report at scan index 2.
        send(32'h0000_0050, 0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (2) @(posedge frame_clk);
        #1 Reset = 1'b1;
        @(negedge frame_clk);
        chk("abort_red", {24'd0, keycode_red}, 32'd0);
        chk("abort_blue", {24'd0, keycode_blue}, 32'd0);
        chk("abort_ready", {31'd0, report_ready}, 32'd1);
        @(posedge frame_clk);
        #1 Reset = 1'b0;
        send(32'h0000_0050, 0, 1'b1, 8'd0, 8'd4, 1'b0, 1'b1);
        send(32'h0000_0000, 0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
        send(32'h4F00_0007, 0, 1'b1, 8'd7, 8'd7, 1'b1, 1'b1);
        drain();

`ifdef BALL_KEYGEN_STALE_TIMEOUT_EN
        repeat (70) @(posedge frame_clk);
        @(negedge frame_clk);
        chk("stale_red", {24'd0, keycode_red}, 32'd0);
        chk("stale_blue", {24'd0, keycode_blue}, 32'd0);
        chk("stale_flag", {31'd0, stale}, 32'd1);
        send(32'h0000_0004, 0, 1'b1, 8'd4, 8'd0, 1'b1, 1'b0);
`else
        repeat (200) @(posedge frame_clk);
        @(negedge frame_clk);
        chk("hold_red", {24'd0, keycode_red}, 32'd7);
        chk("hold_blue", {24'd0, keycode_blue}, 32'd7);
        chk("hold_stale", {31'd0, stale}, 32'd0);
        send(32'h0000_0004, 0, 1'b1, 8'd4, 8'd0, 1'b0, 1'b0);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
